ingress_flow_tagger: RTL and testbench
======================================

# ingress_flow_tagger

Ingress stage placed directly upstream of `buffer_top`. It accepts raw AXI-Stream packets, extracts the flow number from a fixed header beat, and drives that flow number as sideband on every beat of the packet into the buffer's `s_w*` write port. It also enforces a maximum packet length, so no packet reaching the buffer exceeds `MAX_BEATS` beats.

## Interface
- `DATA_WIDTH`, 32: data bus width in bits.
- `FLOWS_W`, 3: width of flow number; matches buffer `FLOWS_W` / `SB_WIDTH`.
- `FLOW_BEAT`, 1: zero-based beat index whose `in_tdata[7:0]` carries the flow byte.
- `MAX_BEATS`, 128: maximum beats per output packet; must be greater than `FLOW_BEAT`.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_tdata`  in  DATA_WIDTH  upstream data.
- `in_tvalid`  in  1  upstream valid.
- `in_tready`  out  1  ready to upstream.
- `in_tlast`  in  1  upstream end of packet.
- `out_tdata`  out  DATA_WIDTH  to buffer `s_wdata`.
- `out_tvalid`  out  1  to buffer `s_wvalid`.
- `out_tready`  in  1  from buffer `s_wready`.
- `out_tlast`  out  1  to buffer `s_wlast`.
- `out_tsideband`  out  FLOWS_W  to buffer `s_wsideband`; flow number, constant for the whole packet.

## Operation
- Header buffer: `FLOW_BEAT+1` entries, each holding data and last.
- Beat counter: `$clog2(MAX_BEATS+1)` bits; counts output beats of the current packet; cleared on every output tlast.
- Flow register: `FLOWS_W` bits; loaded from `in_tdata[FLOWS_W-1:0]` of beat `FLOW_BEAT`; upper flow-byte bits are ignored.

FSM:
- **IDLE**
  - `in_tready=1`.
  - On the first accepted beat, store it in the header buffer and go to HDR.
  - If that beat has tlast, go to FLUSH instead, with flow=0 (short packet).
- **HDR**
  - `in_tready=1`; accepted beats are stored.
  - When beat `FLOW_BEAT` is accepted, load the flow register and go to FLUSH.
  - If tlast arrives before beat `FLOW_BEAT`, set flow=0 and go to FLUSH (short packet).
- **FLUSH**
  - `in_tready=0`.
  - Present buffered beats in order, advancing on `out_tvalid && out_tready`.
  - After the last buffered beat: go to IDLE if it carried tlast, else go to PASS.
- **PASS** (cut-through)
  - `out_tdata=in_tdata`, `out_tvalid=in_tvalid`, `in_tready=out_tready`, `out_tlast=in_tlast | trunc_now`.
  - `trunc_now` = the beat counter equals `MAX_BEATS-1`.
  - Output tlast without input tlast: go to DISCARD. Otherwise output tlast: go to IDLE.
- **DISCARD**
  - `in_tready=1`, `out_tvalid=0`.
  - Consume input beats; on accepted in_tlast go to IDLE.

Boundary conditions:
- An input packet of exactly `MAX_BEATS` beats is not truncated.
- `out_tsideband` holds its value from the first to the last output beat of a packet.
- Zero-length packets do not exist: a beat carrying tlast is always a valid beat.

## Timing
- Reset values: `out_tvalid=0`, `out_tlast=0`, `out_tdata=0`, `out_tsideband=0`, `in_tready=0`, state=IDLE, all counters 0.
- `in_tready` rises one cycle after reset is released.
- Reset asserted mid-packet: all outputs return to their reset values immediately (asynchronous); the partial packet is lost.
- Latency:
  - The first output beat appears on the cycle after beat `FLOW_BEAT` is accepted (`FLOW_BEAT+1` accepted beats, then one cycle).
  - Beats in PASS have zero latency (combinational path).
- FLUSH outputs come from registers.
- AXI-S rules:
  - Once asserted, `out_tvalid` stays high, with data/last/sideband stable, until accepted.
  - `in_tready` never depends on `in_tvalid`.

## Configuration
- `FLOW_TAGGER_STATS_EN`: adds three output ports, each 16 bits and saturating at 0xFFFF.
  - `stat_pkts`: increments on every output tlast.
  - `stat_trunc`: increments on every entry to DISCARD.
  - `stat_short`: increments on every packet whose flow defaulted to 0.
- Reset value of all three counters is 0.
- Without the macro the ports and counters do not exist; data behaviour is identical either way.

## Test plan
- 32-beat packet, beat0=0x00, beat1=0x05, beats 2..31=index, `out_tready=1` → 32 identical beats out, `out_tsideband=5` on all, tlast only on beat 31.
- Flow byte 0xAD on beat 1 → `out_tsideband=3'b101` for the whole packet.
- 1-beat packet 0x07 with tlast → one output beat 0x07 with tlast, sideband 0; `stat_short=1` when the macro is defined.
- 130-beat packet → 128 output beats, tlast forced on beat 127, input beats 128–129 consumed with no output; the next 40-beat packet passes intact; `stat_trunc=1`.
- 4 packets of 16–32 beats with 50% random `out_tready` → byte-exact order preserved, `in_tready=0` throughout FLUSH, no beat lost or duplicated.
- Reset asserted at beat 10 of a PASS packet → `out_tvalid=0` the same cycle; after release, the next packet with flow byte 0x02 is tagged 2.

Source files
------------

// File: rtl/ingress_flow_tagger.sv
// rtl/ingress_flow_tagger.sv - tags each packet with its flow number and caps packet length
// Optional FLOW_TAGGER_STATS_EN adds saturating packet/truncation/short-packet counters.
module ingress_flow_tagger #(
  parameter int DATA_WIDTH = 32,
  parameter int FLOWS_W    = 3,
  parameter int FLOW_BEAT  = 1,
  parameter int MAX_BEATS  = 128
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic [FLOWS_W-1:0]    out_tsideband
`ifdef FLOW_TAGGER_STATS_EN
  ,
  output logic [15:0]           stat_pkts,
  output logic [15:0]           stat_trunc,
  output logic [15:0]           stat_short
`endif
);

  localparam int HDR_N = FLOW_BEAT + 1;
  localparam int IDX_W = $clog2(HDR_N + 1);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FLUSH, S_PASS, S_DISCARD} state_t;

  state_t                  state_q, state_d;
  logic                    ready_en_q, ready_en_d;
  logic [DATA_WIDTH-1:0]   hdr_data_q [HDR_N];
  logic [DATA_WIDTH-1:0]   hdr_data_d [HDR_N];
  logic [HDR_N-1:0]        hdr_last_q, hdr_last_d;
  logic [IDX_W-1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [IDX_W-1:0]        rd_q, rd_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [FLOWS_W-1:0]      flow_q, flow_d;

  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_last;
  logic [IDX_W-1:0]        wr_idx;
  logic                    trunc_now;
  logic                    in_acc;
  logic                    out_hs;
  logic                    pkt_evt;
  logic                    trunc_evt;
  logic                    short_evt;

  always_comb begin
    head_data = '0;
    head_last = 1'b0;
    for (int i = 0; i < HDR_N; i++) begin
      if (rd_q == IDX_W'(i)) begin
        head_data = hdr_data_q[i];
        head_last = hdr_last_q[i];
      end
    end
  end

  assign trunc_now = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  // PASS is a pure combinational cut-through; FLUSH replays the registered header beats.
  always_comb begin
    in_tready     = 1'b0;
    out_tvalid    = 1'b0;
    out_tlast     = 1'b0;
    out_tdata     = head_data;
    out_tsideband = flow_q;
    case (state_q)
      S_IDLE:    in_tready = ready_en_q;
      S_HDR:     in_tready = 1'b1;
      S_FLUSH: begin
        out_tvalid = 1'b1;
        out_tlast  = head_last;
      end
      S_PASS: begin
        out_tdata  = in_tdata;
        out_tvalid = in_tvalid;
        in_tready  = out_tready;
        out_tlast  = in_tlast | trunc_now;
      end
      S_DISCARD: in_tready = 1'b1;
      default:   in_tready = 1'b0;
    endcase
  end

  assign in_acc  = in_tvalid & in_tready;
  assign out_hs  = out_tvalid & out_tready;
  assign pkt_evt = out_hs & out_tlast;
  assign wr_idx  = (state_q == S_IDLE) ? '0 : hdr_cnt_q;

  always_comb begin
    state_d    = state_q;
    ready_en_d = 1'b1;
    hdr_data_d = hdr_data_q;
    hdr_last_d = hdr_last_q;
    hdr_cnt_d  = hdr_cnt_q;
    rd_d       = rd_q;
    beat_cnt_d = beat_cnt_q;
    flow_d     = flow_q;
    trunc_evt  = 1'b0;
    short_evt  = 1'b0;

    if (in_acc && (state_q == S_IDLE || state_q == S_HDR)) begin
      for (int i = 0; i < HDR_N; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          hdr_data_d[i] = in_tdata;
          hdr_last_d[i] = in_tlast;
        end
      end
    end

    if (out_hs) begin
      beat_cnt_d = out_tlast ? '0 : beat_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (in_acc) begin
          hdr_cnt_d = IDX_W'(1);
          rd_d      = '0;
          if (FLOW_BEAT == 0) begin
            flow_d  = in_tdata[FLOWS_W-1:0];
            state_d = S_FLUSH;
          end else if (in_tlast) begin
            flow_d    = '0;
            short_evt = 1'b1;
            state_d   = S_FLUSH;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (in_acc) begin
          hdr_cnt_d = hdr_cnt_q + IDX_W'(1);
          if (hdr_cnt_q == IDX_W'(FLOW_BEAT)) begin
            flow_d  = in_tdata[FLOWS_W-1:0];
            state_d = S_FLUSH;
          end else if (in_tlast) begin
            flow_d    = '0;
            short_evt = 1'b1;
            state_d   = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (out_hs) begin
          rd_d = rd_q + IDX_W'(1);
          if (rd_q == hdr_cnt_q - IDX_W'(1)) begin
            state_d = head_last ? S_IDLE : S_PASS;
          end
        end
      end
      S_PASS: begin
        if (pkt_evt) begin
          if (in_tlast) begin
            state_d = S_IDLE;
          end else begin
            trunc_evt = 1'b1;
            state_d   = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        if (in_acc && in_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
      for (int i = 0; i < HDR_N; i++) begin
        hdr_data_q[i] <= '0;
      end
      hdr_last_q <= '0;
      hdr_cnt_q  <= '0;
      rd_q       <= '0;
      beat_cnt_q <= '0;
      flow_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      hdr_data_q <= hdr_data_d;
      hdr_last_q <= hdr_last_d;
      hdr_cnt_q  <= hdr_cnt_d;
      rd_q       <= rd_d;
      beat_cnt_q <= beat_cnt_d;
      flow_q     <= flow_d;
    end
  end

`ifdef FLOW_TAGGER_STATS_EN
  logic [15:0] stat_pkts_q, stat_pkts_d;
  logic [15:0] stat_trunc_q, stat_trunc_d;
  logic [15:0] stat_short_q, stat_short_d;

  always_comb begin
    stat_pkts_d  = stat_pkts_q;
    stat_trunc_d = stat_trunc_q;
    stat_short_d = stat_short_q;
    if (pkt_evt && stat_pkts_q != 16'hFFFF)    stat_pkts_d  = stat_pkts_q + 16'd1;
    if (trunc_evt && stat_trunc_q != 16'hFFFF) stat_trunc_d = stat_trunc_q + 16'd1;
    if (short_evt && stat_short_q != 16'hFFFF) stat_short_d = stat_short_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_pkts_q  <= '0;
      stat_trunc_q <= '0;
      stat_short_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_trunc_q <= stat_trunc_d;
      stat_short_q <= stat_short_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_trunc = stat_trunc_q;
  assign stat_short = stat_short_q;
`endif

endmodule

// File: tb/tb_ingress_flow_tagger.sv
// tb/tb_ingress_flow_tagger.sv - randomized packet bench with a packet-level reference model
module tb_ingress_flow_tagger;
  localparam int DW = 32;
  localparam int FW = 3;
  localparam int FB = 1;
  localparam int MB = 128;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic          in_tlast = 1'b0;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic          out_tlast;
  logic [FW-1:0] out_tsideband;
`ifdef FLOW_TAGGER_STATS_EN
  logic [15:0]   stat_pkts, stat_trunc, stat_short;
`endif

  always #5 clk = ~clk;

  ingress_flow_tagger #(.DATA_WIDTH(DW), .FLOWS_W(FW), .FLOW_BEAT(FB), .MAX_BEATS(MB)) dut (
    .clk(clk), .rstn(rstn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_tsideband(out_tsideband)
`ifdef FLOW_TAGGER_STATS_EN
    , .stat_pkts(stat_pkts), .stat_trunc(stat_trunc), .stat_short(stat_short)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [FW-1:0] sb;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] pkt[$];
  int            checks = 0;
  int            passes = 0;
  int            rdy_pct = 100;
  int            exp_pkts = 0, exp_trunc = 0, exp_short = 0;
  int            cur_len = 0, last_pkt_len = 0;
  logic [FW-1:0] last_pkt_sb = '0;
  logic [DW-1:0] last_d = '0;
  logic          last_l = 1'b0;
  logic          hold_pending = 1'b0;
  logic [DW+FW:0] held = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Packet-level model: flow is the low FW bits of beat FB (0 if the packet is shorter),
  // and only the first MB beats leave, the last of them carrying tlast.
  task automatic model_pkt();
    int n, outn;
    logic [FW-1:0] sb;
    n    = pkt.size();
    sb   = (n > FB) ? pkt[FB][FW-1:0] : '0;
    outn = (n > MB) ? MB : n;
    if (n <= FB) exp_short++;
    if (n > MB) exp_trunc++;
    exp_pkts++;
    for (int i = 0; i < outn; i++) exp_q.push_back('{d: pkt[i], l: (i == outn - 1), sb: sb});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Scoreboard and output-stability monitor, sampled mid-cycle.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (hold_pending) begin
        chk("hold_valid", out_tvalid, 1);
        chk("hold_stable", {out_tdata, out_tlast, out_tsideband}, held);
      end
      hold_pending = rstn && out_tvalid && !out_tready;
      held = {out_tdata, out_tlast, out_tsideband};
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", out_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_tdata, e.d);
          chk("beat_last", out_tlast, e.l);
          chk("beat_sideband", out_tsideband, e.sb);
        end
        cur_len++;
        last_d = out_tdata;
        last_l = out_tlast;
        if (out_tlast) begin
          last_pkt_len = cur_len;
          last_pkt_sb  = out_tsideband;
          cur_len      = 0;
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    logic hs;
    int   k;
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      hs = in_tready;
      @(posedge clk);
      #1;
      k++;
    end while (!hs && k < 1000);
    if (!hs) begin
      checks++;
      $display("FAIL in_accept_timeout: got no acceptance in %0d cycles, expected acceptance", k);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input bit gaps);
    int n, hb;
    model_pkt();
    n  = pkt.size();
    hb = (n - 1 < FB) ? n - 1 : FB;
    for (int i = 0; i < n; i++) begin
      send_beat(pkt[i], i == n - 1);
      if (i == hb) begin
        @(negedge clk);
        chk("flush_in_tready", in_tready, 0);
        chk("flush_latency_valid", out_tvalid, 1);
        @(posedge clk);
        #1;
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic make_pkt(input int n, input logic [7:0] flow_byte);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back($urandom());
    if (n > FB) pkt[FB][7:0] = flow_byte;
  endtask

  task automatic check_stats();
`ifdef FLOW_TAGGER_STATS_EN
    chk("stat_pkts", stat_pkts, exp_pkts);
    chk("stat_trunc", stat_trunc, exp_trunc);
    chk("stat_short", stat_short, exp_short);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_out_tvalid", out_tvalid, 0);
    chk("reset_out_tlast", out_tlast, 0);
    chk("reset_out_tdata", out_tdata, 0);
    chk("reset_out_tsideband", out_tsideband, 0);
    chk("reset_in_tready", in_tready, 0);
    check_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("in_tready_before_edge", in_tready, 0);
    @(posedge clk);
    #1;
    chk("in_tready_after_edge", in_tready, 1);

    pkt.delete();
    pkt.push_back(32'h0);
    pkt.push_back(32'h5);
    for (int i = 2; i < 32; i++) pkt.push_back(i);
    send_pkt(0);
    wait_drain();
    chk("pkt32_len", last_pkt_len, 32);
    chk("pkt32_sideband", last_pkt_sb, 5);
    chk("pkt32_last_data", last_d, 31);

    make_pkt(8, 8'hAD);
    send_pkt(0);
    wait_drain();
    chk("flow_AD_sideband", last_pkt_sb, 3'b101);

    pkt.delete();
    pkt.push_back(32'h7);
    send_pkt(0);
    wait_drain();
    chk("short_data", last_d, 32'h7);
    chk("short_last", last_l, 1);
    chk("short_sideband", last_pkt_sb, 0);
    chk("short_len", last_pkt_len, 1);
    check_stats();

    make_pkt(130, 8'h03);
    send_pkt(0);
    wait_drain();
    chk("trunc_len", last_pkt_len, 128);
    make_pkt(40, 8'h06);
    send_pkt(0);
    wait_drain();
    chk("after_trunc_len", last_pkt_len, 40);
    chk("after_trunc_sideband", last_pkt_sb, 6);
    check_stats();

    make_pkt(MB, 8'h04);
    send_pkt(0);
    wait_drain();
    chk("exact_max_len", last_pkt_len, MB);

    rdy_pct = 50;
    for (int p = 0; p < 4; p++) begin
      make_pkt($urandom_range(16, 32), 8'($urandom()));
      send_pkt(1);
    end
    for (int p = 0; p < 10; p++) begin
      make_pkt($urandom_range(1, 40), 8'($urandom()));
      send_pkt(1);
    end
    make_pkt(MB + 3, 8'h01);
    send_pkt(1);
    wait_drain();
    check_stats();

    rdy_pct = 100;
    @(posedge clk);
    #1;
    make_pkt(20, 8'h03);
    model_pkt();
    for (int i = 0; i < 10; i++) send_beat(pkt[i], 1'b0);
    in_tdata  = pkt[10];
    in_tvalid = 1'b1;
    #2;
    rstn = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
    cur_len = 0;
    exp_pkts = 0;
    exp_trunc = 0;
    exp_short = 0;
    #1;
    chk("midreset_out_tvalid", out_tvalid, 0);
    chk("midreset_in_tready", in_tready, 0);
    chk("midreset_out_tsideband", out_tsideband, 0);
    in_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    make_pkt(12, 8'h02);
    send_pkt(0);
    wait_drain();
    chk("post_reset_sideband", last_pkt_sb, 2);
    chk("post_reset_len", last_pkt_len, 12);
    check_stats();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
